// File: rtl/clock_choice.sv
// clock_choice
//   Selects the system step clock: either a free-running clock divided down from
//   clk, or a manual single-step clock taken from a push-button. The output is a
//   registered, glitch-free level in the clk domain. A source switch is only taken
//   while both the output and the new source are low, so no runt pulse can appear.
//
// Optional feature macro: CLOCK_CHOICE_DEBOUNCE_EN
//   defined     - the button passes a counter debouncer (DEBOUNCE_CYCLES stable cycles)
//   not defined - the synchronized button level is used directly (3-edge latency)
//
// Parameters
//   FREE_HALF_PERIOD  clk cycles per half-period of the free-running clock (>= 1)
//   DEBOUNCE_CYCLES   stable clk cycles needed to accept a button change (>= 1)
//   CNT_W             width of the divider and debounce counters
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   s            in   mode: 0 = free-running clock, 1 = button clock
//   BtnClk       in   raw asynchronous push-button level
//   ClockChoice  out  selected step clock, registered
module clock_choice #(
    parameter int unsigned FREE_HALF_PERIOD = 4,
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned CNT_W            = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic BtnClk,
    output logic ClockChoice
);

    // Both counter end values must fit in CNT_W bits.
    if (FREE_HALF_PERIOD < 1 || DEBOUNCE_CYCLES < 1 ||
        ((FREE_HALF_PERIOD - 1) >> CNT_W) != 0 ||
        ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : gBadParams
        $error("clock_choice: parameter out of range");
    end

    localparam logic [CNT_W-1:0] DivLast = CNT_W'(FREE_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             sMeta, sSync;
    logic             bMeta, bSync;
    logic [CNT_W-1:0] divCnt;
    logic             freeClk;
    logic             btnDb;
    logic             sel;
    logic             selD;
    logic             target;

    // Two-flop synchronizers for the asynchronous mode select and button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sMeta <= 1'b0;
            sSync <= 1'b0;
            bMeta <= 1'b0;
            bSync <= 1'b0;
        end else begin
            sMeta <= s;
            sSync <= sMeta;
            bMeta <= BtnClk;
            bSync <= bMeta;
        end
    end

    // Free-running divider; keeps running in button mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt  <= '0;
            freeClk <= 1'b0;
        end else if (divCnt == DivLast) begin
            divCnt  <= '0;
            freeClk <= ~freeClk;
        end else begin
            divCnt <= divCnt + CntOne;
        end
    end

`ifdef CLOCK_CHOICE_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] dbCnt;

    // Accept a new level only after it has differed from btnDb for
    // DEBOUNCE_CYCLES consecutive cycles; any return to btnDb restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbCnt <= '0;
            btnDb <= 1'b0;
        end else if (bSync == btnDb) begin
            dbCnt <= '0;
        end else if (dbCnt == DbLast) begin
            dbCnt <= '0;
            btnDb <= bSync;
        end else begin
            dbCnt <= dbCnt + CntOne;
        end
    end
`else
    assign btnDb = bSync;
`endif

    // Switch only when the output and the requested source are both low.
    always_comb begin
        target = sSync ? btnDb : freeClk;
        selD   = sel;
        if (!ClockChoice && !target) begin
            selD = sSync;
        end
    end

    // The output follows the next selection, so the cycle a switch happens it
    // already shows the (low) new source instead of one last sample of the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 1'b0;
            ClockChoice <= 1'b0;
        end else begin
            sel         <= selD;
            ClockChoice <= selD ? btnDb : freeClk;
        end
    end

endmodule

// File: tb/tb_clock_choice.sv
// Bench for clock_choice with FREE_HALF_PERIOD=4, DEBOUNCE_CYCLES=4.
// Expected outputs are hand-derived and switch on CLOCK_CHOICE_DEBOUNCE_EN.
module tb_clock_choice;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic s      = 1'b0;
    logic BtnClk = 1'b0;
    logic ClockChoice;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic s;
        logic b;
        logic exp;
    } vec_t;

    vec_t vecs[$];

    clock_choice #(
        .FREE_HALF_PERIOD(4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (s),
        .BtnClk     (BtnClk),
        .ClockChoice(ClockChoice)
    );

    always #5 clk = ~clk;

    task automatic addRun(input logic sv, input logic bv, input logic ev, input int n);
        vec_t v;
        v.s   = sv;
        v.b   = bv;
        v.exp = ev;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: ClockChoice=%b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic sv, input logic bv);
        s      = sv;
        BtnClk = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table, one entry per clk edge after reset release (edge 1 = first entry).
        // Free-run: 0 for 4 sampled edges, then high from edge 5, 4 high / 4 low.
        addRun(1'b0, 1'b0, 1'b0, 4);   // edges 1-4
        addRun(1'b0, 1'b0, 1'b1, 4);   // 5-8
        addRun(1'b0, 1'b0, 1'b0, 4);   // 9-12
        addRun(1'b0, 1'b0, 1'b1, 4);   // 13-16
        addRun(1'b0, 1'b0, 1'b0, 4);   // 17-20
        // s rises during the high phase: the phase completes, then output stays low.
        addRun(1'b1, 1'b0, 1'b1, 4);   // 21-24
        addRun(1'b1, 1'b0, 1'b0, 8);   // 25-32
`ifdef CLOCK_CHOICE_DEBOUNCE_EN
        // Button press held 20 cycles: visible 7 edges after the change.
        addRun(1'b1, 1'b1, 1'b0, 6);   // 33-38
        addRun(1'b1, 1'b1, 1'b1, 14);  // 39-52
        addRun(1'b1, 1'b0, 1'b1, 6);   // 53-58
        addRun(1'b1, 1'b0, 1'b0, 4);   // 59-62
        // Bounce 3 high / 1 low / 2 high, then a 1-cycle glitch: all filtered.
        addRun(1'b1, 1'b1, 1'b0, 3);   // 63-65
        addRun(1'b1, 1'b0, 1'b0, 1);   // 66
        addRun(1'b1, 1'b1, 1'b0, 2);   // 67-68
        addRun(1'b1, 1'b0, 1'b0, 8);   // 69-76
        addRun(1'b1, 1'b1, 1'b0, 1);   // 77
        addRun(1'b1, 1'b0, 1'b0, 7);   // 78-84
`else
        // No debouncer: 3-edge latency and every glitch passes through.
        addRun(1'b1, 1'b1, 1'b0, 2);   // 33-34
        addRun(1'b1, 1'b1, 1'b1, 18);  // 35-52
        addRun(1'b1, 1'b0, 1'b1, 2);   // 53-54
        addRun(1'b1, 1'b0, 1'b0, 8);   // 55-62
        addRun(1'b1, 1'b1, 1'b0, 2);   // 63-64 (inputs 63-65 high)
        addRun(1'b1, 1'b1, 1'b1, 1);   // 65
        addRun(1'b1, 1'b0, 1'b1, 1);   // 66
        addRun(1'b1, 1'b1, 1'b1, 1);   // 67
        addRun(1'b1, 1'b1, 1'b0, 1);   // 68 (1-cycle low gap)
        addRun(1'b1, 1'b0, 1'b1, 2);   // 69-70
        addRun(1'b1, 1'b0, 1'b0, 6);   // 71-76
        addRun(1'b1, 1'b1, 1'b0, 1);   // 77
        addRun(1'b1, 1'b0, 1'b0, 1);   // 78
        addRun(1'b1, 1'b0, 1'b1, 1);   // 79 (1-cycle glitch)
        addRun(1'b1, 1'b0, 1'b0, 5);   // 80-84
`endif

        // Reset with s=1, BtnClk=1: output low at once and while held.
        s      = 1'b1;
        BtnClk = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_now", 0, ClockChoice, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1);
            check("reset_hold", i, ClockChoice, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].b);
            check("table", i + 1, ClockChoice, vecs[i].exp);
        end

        // Fresh start; s pulses high for 2 cycles inside the first high phase
        // and returns before a switch is possible, so free-run continues.
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step((n == 6 || n == 7) ? 1'b1 : 1'b0, 1'b0);
            check("s_glitch", n, ClockChoice, ((n - 1) / 4) % 2 == 1 ? 1'b1 : 1'b0);
        end

        // Output is high after edge 14; reset mid-cycle must clear it immediately.
        #3 rst_n = 1'b0;
        #1 check("reset_mid", 0, ClockChoice, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step(1'b1, 1'b1);
            check("reset_mid_hold", i, ClockChoice, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
